// File: rtl/capture_engine.sv
// capture_engine: trigger-and-capture core of the logic analyzer.
// Samples an 8-bit probe bus on sample_strobe and keeps a pre-trigger
// history in a 16-entry ring FIFO. On a qualified edge of one channel
// it streams the window (history, trigger, post) to SDRAM from addr 0.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   arm, soft_reset  host pulses: start capture / abort to idle
//   probe_input      synchronized probe bus, pushed on sample_strobe
//   trig_ch/mode     trigger channel, 0 = rising, 1 = falling
//   window_preset    window size select, latched on arm
//   armed, captured  status; pause_refresh mirrors armed
//   total_samples    window length of the latched preset
//   sdram_wr_*       write port, transfer on req && ready
module capture_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        soft_reset,
   input  logic [7:0]  probe_input,
   input  logic        sample_strobe,
   input  logic [2:0]  trig_ch,
   input  logic        trig_mode,
   input  logic [1:0]  window_preset,
   output logic        armed,
   output logic        captured,
   output logic [8:0]  total_samples,
   output logic        pause_refresh,
   output logic        sdram_wr_req,
   output logic [12:0] sdram_wr_addr,
   output logic [7:0]  sdram_wr_data,
   input  logic        sdram_wr_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT,
      S_POST,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  ch_q;
   logic        mode_q;
   logic [1:0]  preset_q;
   logic [7:0]  mem_q [16];
   logic [3:0]  rd_q, wr_q;
   logic [4:0]  cnt_q;
   logic [8:0]  win_q;
   logic        prev_q;
   logic        armed_q, capt_q;
   logic        req_q;
   logic [12:0] addr_q;
   logic [7:0]  data_q;

   logic [8:0]  total, pre;
   logic        bit_new, edge_hit;
   logic        accept, load;
   logic        push, drop, win_inc, done;

   always_comb begin
      total = 9'd38;
      pre   = 9'd2;
      unique case (preset_q)
         2'd0: begin total = 9'd38;  pre = 9'd2;  end
         2'd1: begin total = 9'd76;  pre = 9'd4;  end
         2'd2: begin total = 9'd133; pre = 9'd7;  end
         2'd3: begin total = 9'd266; pre = 9'd13; end
         default: ;
      endcase
   end

   assign bit_new  = probe_input[ch_q];
   assign edge_hit = mode_q ? (prev_q & ~bit_new)
                            : (~prev_q & bit_new);
   assign accept   = req_q & sdram_wr_ready;

   // The output register acts as the FIFO head once triggered: it is
   // refilled on the same edge that retires the current write.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      drop    = 1'b0;
      win_inc = 1'b0;
      done    = 1'b0;
      load    = (state_q == S_POST) && (!req_q || accept)
                && (cnt_q != 5'd0);
      unique case (state_q)
         S_IDLE: ;
         S_PRE: begin
            if (sample_strobe) begin
               push    = 1'b1;
               win_inc = 1'b1;
               if (win_q + 9'd1 == pre) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (sample_strobe) begin
               push = 1'b1;
               if (edge_hit) begin
                  win_inc = 1'b1;
                  state_d = S_POST;
               end else begin
                  // slide the history so exactly pre entries remain
                  drop = 1'b1;
               end
            end
         end
         S_POST: begin
            if (sample_strobe && win_q != total
                && cnt_q != 5'd16) begin
               push    = 1'b1;
               win_inc = 1'b1;
            end
            if (win_q == total && cnt_q == 5'd0 && accept) begin
               done    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (arm) state_d = S_PRE;
      if (soft_reset) state_d = S_IDLE;
      if (arm || soft_reset) begin
         push    = 1'b0;
         drop    = 1'b0;
         win_inc = 1'b0;
         done    = 1'b0;
         load    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= probe_input;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q     <= 3'd0;
         mode_q   <= 1'b0;
         preset_q <= 2'd0;
         rd_q     <= 4'd0;
         wr_q     <= 4'd0;
         cnt_q    <= 5'd0;
         win_q    <= 9'd0;
         prev_q   <= 1'b0;
         armed_q  <= 1'b0;
         capt_q   <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= 13'd0;
         data_q   <= 8'd0;
      end else if (soft_reset) begin
         rd_q    <= 4'd0;
         wr_q    <= 4'd0;
         cnt_q   <= 5'd0;
         armed_q <= 1'b0;
         capt_q  <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= 13'd0;
      end else if (arm) begin
         ch_q     <= trig_ch;
         mode_q   <= trig_mode;
         preset_q <= window_preset;
         rd_q     <= 4'd0;
         wr_q     <= 4'd0;
         cnt_q    <= 5'd0;
         win_q    <= 9'd0;
         armed_q  <= 1'b1;
         capt_q   <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= 13'd0;
      end else begin
         if (push) begin
            wr_q   <= wr_q + 4'd1;
            prev_q <= bit_new;
         end
         if (drop || load) rd_q <= rd_q + 4'd1;
         cnt_q <= cnt_q + {4'd0, push} - {4'd0, drop || load};
         if (win_inc) win_q <= win_q + 9'd1;
         if (load) begin
            req_q  <= 1'b1;
            data_q <= mem_q[rd_q];
         end else if (accept) begin
            req_q <= 1'b0;
         end
         if (accept) addr_q <= addr_q + 13'd1;
         if (done) begin
            armed_q <= 1'b0;
            capt_q  <= 1'b1;
         end
      end
   end

   assign armed         = armed_q;
   assign pause_refresh = armed_q;
   assign captured      = capt_q;
   assign total_samples = total;
   assign sdram_wr_req  = req_q;
   assign sdram_wr_addr = addr_q;
   assign sdram_wr_data = data_q;

endmodule

// File: tb/tb_capture_engine.sv
// tb_capture_engine: randomized bench for capture_engine.
// Reference model recomputes the capture window from the sample log.
module tb_capture_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arm = 1'b0;
   logic        soft_reset = 1'b0;
   logic [7:0]  probe_input = 8'd0;
   logic        sample_strobe = 1'b0;
   logic [2:0]  trig_ch = 3'd0;
   logic        trig_mode = 1'b0;
   logic [1:0]  window_preset = 2'd0;
   logic        armed, captured, pause_refresh;
   logic [8:0]  total_samples;
   logic        sdram_wr_req;
   logic [12:0] sdram_wr_addr;
   logic [7:0]  sdram_wr_data;
   logic        sdram_wr_ready = 1'b1;

   always #20 clk = ~clk;

   capture_engine dut (
      .clk            (clk),
      .rst            (rst),
      .arm            (arm),
      .soft_reset     (soft_reset),
      .probe_input    (probe_input),
      .sample_strobe  (sample_strobe),
      .trig_ch        (trig_ch),
      .trig_mode      (trig_mode),
      .window_preset  (window_preset),
      .armed          (armed),
      .captured       (captured),
      .total_samples  (total_samples),
      .pause_refresh  (pause_refresh),
      .sdram_wr_req   (sdram_wr_req),
      .sdram_wr_addr  (sdram_wr_addr),
      .sdram_wr_data  (sdram_wr_data),
      .sdram_wr_ready (sdram_wr_ready)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // reference model state
   logic [7:0] samples [$];
   logic [7:0] sdram [8192];
   int m_ch = 0, m_mode = 0, m_pre = 2, m_total = 38;
   int wr_cnt = 0;
   bit rnd_rdy = 1'b0;
   bit hold_req = 1'b0;
   int hold_cnt = 0;

   function automatic int pre_of(int p);
      case (p)
         0: return 2;
         1: return 4;
         2: return 7;
         default: return 13;
      endcase
   endfunction

   function automatic int total_of(int p);
      case (p)
         0: return 38;
         1: return 76;
         2: return 133;
         default: return 266;
      endcase
   endfunction

   // j-th window element: trigger is the first edge at index >= pre,
   // window starts pre samples before it.
   function automatic int exp_sample(int j);
      logic b0, b1;
      logic [7:0] s0, s1;
      for (int k = m_pre; k < samples.size(); k++) begin
         s0 = samples[k-1];
         s1 = samples[k];
         b0 = s0[m_ch];
         b1 = s1[m_ch];
         if ((m_mode == 0 && !b0 && b1) ||
             (m_mode == 1 && b0 && !b1)) begin
            if (k - m_pre + j < samples.size())
               return int'(samples[k - m_pre + j]);
            return -1;
         end
      end
      return -1;
   endfunction

   // ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (hold_req && sdram_wr_req) begin
            hold_req = 1'b0;
            hold_cnt = 5;
         end
         if (hold_cnt > 0) begin
            sdram_wr_ready = 1'b0;
            hold_cnt--;
         end else if (rnd_rdy) begin
            sdram_wr_ready = ($urandom_range(0, 3) != 0);
         end else begin
            sdram_wr_ready = 1'b1;
         end
      end
   end

   // compare process
   bit          stall_q = 1'b0;
   logic [12:0] last_addr;
   logic [7:0]  last_data;

   always @(negedge clk) begin
      if (!rst) begin
         chk("pause_eq_armed", int'(pause_refresh), int'(armed));
         chk("total_samples", int'(total_samples), m_total);
         if (sdram_wr_req && stall_q) begin
            chk("addr_stable", int'(sdram_wr_addr), int'(last_addr));
            chk("data_stable", int'(sdram_wr_data), int'(last_data));
         end
         if (sdram_wr_req && sdram_wr_ready) begin
            chk("wr_addr", int'(sdram_wr_addr), wr_cnt);
            chk("wr_in_window", int'(wr_cnt < m_total), 1);
            chk("wr_data", int'(sdram_wr_data), exp_sample(wr_cnt));
            sdram[sdram_wr_addr] = sdram_wr_data;
            wr_cnt++;
         end
      end
      stall_q   = sdram_wr_req && !sdram_wr_ready;
      last_addr = sdram_wr_addr;
      last_data = sdram_wr_data;
   end

   task automatic do_arm(int ch, int mode, int preset);
      @(negedge clk);
      trig_ch       = 3'(ch);
      trig_mode     = 1'(mode);
      window_preset = 2'(preset);
      arm = 1'b1;
      @(posedge clk);
      #1;
      m_ch    = ch;
      m_mode  = mode;
      m_pre   = pre_of(preset);
      m_total = total_of(preset);
      wr_cnt  = 0;
      samples.delete();
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic do_soft_reset();
      @(negedge clk);
      soft_reset = 1'b1;
      @(posedge clk);
      #1;
      wr_cnt = 0;
      samples.delete();
      @(negedge clk);
      soft_reset = 1'b0;
   endtask

   task automatic send_strobe(logic [7:0] v);
      int gap;
      gap = $urandom_range(16, 22);
      repeat (gap - 1) @(negedge clk);
      probe_input   = v;
      sample_strobe = 1'b1;
      samples.push_back(v);
      @(negedge clk);
      sample_strobe = 1'b0;
   endtask

   // kind 0: trigger bit inactive for nbefore strobes then active,
   // other bits from base; kind 1: fully random bytes
   task automatic run_capture(int ch, int mode, int preset,
                              int kind, int nbefore,
                              logic [7:0] base);
      int lim, n, t;
      logic [7:0] v;
      do_arm(ch, mode, preset);
      lim = total_of(preset) + nbefore + 64;
      n = 0;
      while (!captured && n < lim) begin
         if (kind == 0) begin
            v = base;
            v[ch] = (n < nbefore) ? mode[0] : ~mode[0];
         end else begin
            v = 8'($urandom);
         end
         send_strobe(v);
         n++;
      end
      t = 0;
      while (!captured && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("captured", int'(captured), 1);
      chk("armed_after", int'(armed), 0);
      chk("write_count", wr_cnt, m_total);
      chk("req_idle", int'(sdram_wr_req), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_armed", int'(armed), 0);
      chk("rst_captured", int'(captured), 0);
      chk("rst_pause", int'(pause_refresh), 0);
      chk("rst_req", int'(sdram_wr_req), 0);
      chk("rst_addr", int'(sdram_wr_addr), 0);
      chk("rst_data", int'(sdram_wr_data), 0);
      chk("rst_total", int'(total_samples), 38);

      do_arm(0, 0, 0);
      repeat (2) @(negedge clk);
      chk("arm_armed", int'(armed), 1);
      chk("arm_pause", int'(pause_refresh), 1);
      chk("arm_captured", int'(captured), 0);
      chk("arm_no_req", int'(sdram_wr_req), 0);

      // preset 0, rising on ch0
      run_capture(0, 0, 0, 0, 5, 8'h00);
      chk("r_sd0", int'(sdram[0]), 8'h00);
      chk("r_sd1", int'(sdram[1]), 8'h00);
      chk("r_sd2", int'(sdram[2]), 8'h01);
      chk("r_sd37", int'(sdram[37]), 8'h01);

      // captured clears on soft_reset
      do_soft_reset();
      @(negedge clk);
      chk("sr_captured", int'(captured), 0);

      // preset 0, falling on ch5
      run_capture(5, 1, 0, 0, 5, 8'h00);
      chk("f_sd0", int'(sdram[0]), 8'h20);
      chk("f_sd1", int'(sdram[1]), 8'h20);
      chk("f_sd2", int'(sdram[2]), 8'h00);

      // preset 3, rising on ch0, 5-clock ready stall mid-drain
      hold_req = 1'b1;
      run_capture(0, 0, 3, 0, 20, 8'h00);
      chk("p3_total", int'(total_samples), 266);
      chk("p3_sd12", int'(sdram[12]), 8'h00);
      chk("p3_sd13", int'(sdram[13]), 8'h01);
      chk("p3_sd265", int'(sdram[265]), 8'h01);

      // abort while armed
      do_arm(2, 0, 1);
      repeat (2) @(negedge clk);
      do_soft_reset();
      @(negedge clk);
      chk("ab_armed", int'(armed), 0);
      chk("ab_captured", int'(captured), 0);
      chk("ab_req", int'(sdram_wr_req), 0);
      chk("ab_addr", int'(sdram_wr_addr), 0);
      run_capture(3, 1, 1, 0, 8, 8'h5a);

      // randomized captures with random back-pressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_capture($urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 2), 1, 0, 8'h00);
      end
      rnd_rdy = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL timeout: sim time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/capture_engine.md
# capture_engine

Trigger-and-capture core of the logic analyzer. It samples an 8-bit probe bus on a sample strobe and keeps a short pre-trigger history. On a qualified edge on one selected channel, it streams a fixed-length window (pre-trigger history, then trigger and post-trigger samples) into SDRAM at addresses starting from 0. It sits between the probe input synchronizers/sample-rate divider and the SDRAM controller write port, and exposes status to the host register block.

## Interface
- No parameters.
- clk  in  1  system clock (25 MHz nominal).
- rst  in  1  synchronous active-high reset.
- arm  in  1  one-cycle pulse: latch config, start a new capture.
- soft_reset  in  1  one-cycle pulse: abort and return to idle.
- probe_input  in  8  probe bus, already synchronized to clk.
- sample_strobe  in  1  one-cycle sample enable (e.g. 1 MHz); minimum spacing 16 clocks.
- trig_ch  in  3  trigger channel index into probe_input.
- trig_mode  in  1  0 = rising edge, 1 = falling edge.
- window_preset  in  2  window size select.
- armed  out  1  capture in progress, i.e. armed and not yet complete.
- captured  out  1  window fully written to SDRAM.
- total_samples  out  9  total window length of the latched preset.
- pause_refresh  out  1  request SDRAM controller to suspend refresh; equals armed.
- sdram_wr_req  out  1  write request.
- sdram_wr_addr  out  13  write address.
- sdram_wr_data  out  8  write data.
- sdram_wr_ready  in  1  controller accepts the write on a clock where req and ready are both 1.

## Operation
- Preset table (total/pre-trigger): 0 = 38/2, 1 = 76/4, 2 = 133/7, 3 = 266/13. Post-trigger count = total − pre, and includes the trigger sample.
- On `arm`, latch trig_ch, trig_mode and window_preset. Clear captured, set armed, empty the FIFO, clear the sample counters, set the write address to 0, and enter PRETRIG. `arm` while busy restarts the capture the same way.
- Storage is a 16-entry ring FIFO of samples. Every sample_strobe pushes probe_input.
- States:
  - IDLE: no pushes.
  - PRETRIG: push samples; once `pre` samples are held, go to WAIT_TRIG.
  - WAIT_TRIG: each push compares the new trigger bit with the previous sample's bit. With no edge, drop the oldest entry so exactly `pre` entries remain. A rising edge (0→1, mode 0) or falling edge (1→0, mode 1) makes that sample the trigger sample: keep it, stop dropping, and go to POST.
  - POST: keep pushing until `total` samples have been pushed since arm (including pre-trigger samples), then stop pushing.
  - DONE: reached when the FIFO has drained and the last write has been accepted. Clear armed, set captured, go to IDLE.
- No trigger can be detected before `pre` samples are held. The previous-sample register is initialized from the first sample after arm.
- Writer, active in all non-IDLE states after the trigger: while the FIFO is non-empty, drive req=1 with data = FIFO head and the current address. On req&&ready, pop the head and increment the address. The next entry, if any, is presented on the following cycle.
- Result: SDRAM[0..pre-1] holds the pre-trigger samples oldest first, SDRAM[pre] holds the trigger sample, and the last address is total−1.
- FIFO full on a strobe in POST: the sample is discarded and not counted.
- soft_reset or rst: go to IDLE, clear armed/captured/req, empty the FIFO, set the address to 0. soft_reset wins over a simultaneous arm.
- total_samples is a combinational decode of the latched preset.

## Timing
- Reset values: armed=0, captured=0, pause_refresh=0, sdram_wr_req=0, sdram_wr_addr=0, sdram_wr_data=0, latched preset=0 (total_samples=38).
- All outputs except total_samples are registered.
- armed rises on the clock after arm is sampled.
- A strobe's sample is in the FIFO on the next clock.
- The first write request follows the trigger strobe by at most 2 clocks.
- With ready held high, each write takes 1 clock (request, accept, then next entry), so the 13-sample pre-buffer drains well within one sample period.
- captured rises and armed falls one clock after the final accepted write.
- captured holds until the next arm, soft_reset or rst.
- addr/data are stable while req=1 and ready=0.

## Test plan
- Reset, arm pulse, wait 100 ns -> armed=1, pause_refresh=1, captured=0, no writes.
- Preset 0, rising edge on ch0: input 0x00 for 5 µs, then 0x01 -> captured=1, exactly 38 accepted writes to addresses 0..37, addr 2 = 0x01, addr 0–1 = 0x00.
- Preset 0, falling edge on ch5: input 0x20 before arm, drop to 0x00 after 5 µs -> captured=1, SDRAM[0] and SDRAM[1] have bit 5 = 1, SDRAM[2] = 0x00.
- Preset 3, rising edge on ch0 after 20 µs -> total_samples=266, 266 writes, captured=1.
- Arm then soft_reset after 100 ns -> armed=0, captured=0, req=0; a subsequent arm/capture starts again at addr 0.
- Hold ready low for 5 clocks mid-drain -> addr/data stable, no lost or duplicated samples, sequential addresses.
